// File: rtl/calc_port_responder.sv
// Single-port calc2 responder: two-cycle request capture, 3-stage add/sub path,
// 1-stage shift/invalid path and a small holding FIFO. Macro CALC_SHIFT_EN enables the shifter.
module calc_port_responder #(
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 2,
  parameter int BUF_DEPTH = 2
) (
  input  logic              c_clk,
  input  logic              reset,
  // Request: non-zero cmd with op1/tag in one cycle, op2 on the next; no backpressure.
  input  logic [3:0]        req_cmd_in,
  input  logic [DATA_W-1:0] req_data_in,
  input  logic [TAG_W-1:0]  req_tag_in,
  // Response: out_resp != 0 marks a single-cycle response; no ready, never stalled.
  output logic [1:0]        out_resp,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              err_overrun,
  output logic [0:0]        dbg_state_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OP2  = 1'b1;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
`ifdef CALC_SHIFT_EN
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;
`endif

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] BUF_FULL = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

  // ---------------------------------------------------------------- capture FSM
  logic [0:0]        state_q, state_d;
  logic [3:0]        cmd_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] op1_q;
  logic              dispatch;
  logic              is_long;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_cmd_in != 4'd0) state_d = ST_OP2;
      ST_OP2:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= 4'd0;
      tag_q   <= '0;
      op1_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_cmd_in != 4'd0) begin
        cmd_q <= req_cmd_in;
        tag_q <= req_tag_in;
        op1_q <= req_data_in;
      end
    end
  end

  assign dbg_state_o = state_q;
  assign dispatch    = (state_q == ST_OP2);
  assign is_long     = (cmd_q == CMD_ADD) || (cmd_q == CMD_SUB);

  // ---------------------------------------------------------------- short path
  // Evaluated in the op2 cycle; the output register or the FIFO is its one stage.
  logic              sh_v;
  logic [1:0]        sh_resp;
  logic [DATA_W-1:0] sh_data;

  assign sh_v = dispatch && !is_long;

  always_comb begin
    sh_resp = RESP_ERR;
    sh_data = '0;
`ifdef CALC_SHIFT_EN
    case (cmd_q)
      CMD_SHL: begin
        sh_resp = RESP_OK;
        sh_data = op1_q << req_data_in[4:0];
      end
      CMD_SHR: begin
        sh_resp = RESP_OK;
        sh_data = op1_q >> req_data_in[4:0];
      end
      default: begin
        sh_resp = RESP_ERR;
        sh_data = '0;
      end
    endcase
`endif
  end

  // ---------------------------------------------------------------- long path
  logic              l1_v_q, l1_sub_q;
  logic [TAG_W-1:0]  l1_tag_q;
  logic [DATA_W-1:0] l1_op1_q, l1_op2_q;
  logic              l2_v_q;
  logic [1:0]        l2_resp_q, l2_resp_d;
  logic [DATA_W-1:0] l2_data_q, l2_data_d;
  logic [TAG_W-1:0]  l2_tag_q;
  logic [DATA_W:0]   l1_sum;

  assign l1_sum = {1'b0, l1_op1_q} + {1'b0, l1_op2_q};

  always_comb begin
    l2_resp_d = RESP_OK;
    l2_data_d = '0;
    if (l1_sub_q) begin
      if (l1_op2_q > l1_op1_q) l2_resp_d = RESP_ERR;
      else                     l2_data_d = l1_op1_q - l1_op2_q;
    end else begin
      if (l1_sum[DATA_W]) l2_resp_d = RESP_ERR;
      else                l2_data_d = l1_sum[DATA_W-1:0];
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      l1_v_q    <= 1'b0;
      l1_sub_q  <= 1'b0;
      l1_tag_q  <= '0;
      l1_op1_q  <= '0;
      l1_op2_q  <= '0;
      l2_v_q    <= 1'b0;
      l2_resp_q <= RESP_NONE;
      l2_data_q <= '0;
      l2_tag_q  <= '0;
    end else begin
      l1_v_q <= dispatch && is_long;
      if (dispatch && is_long) begin
        l1_sub_q <= (cmd_q == CMD_SUB);
        l1_tag_q <= tag_q;
        l1_op1_q <= op1_q;
        l1_op2_q <= req_data_in;
      end
      l2_v_q    <= l1_v_q;
      l2_resp_q <= l1_v_q ? l2_resp_d : RESP_NONE;
      l2_data_q <= l1_v_q ? l2_data_d : '0;
      l2_tag_q  <= l1_v_q ? l1_tag_q : '0;
    end
  end

  // ---------------------------------------------------------------- holding FIFO
  logic [1:0]        buf_resp_q [BUF_DEPTH];
  logic [DATA_W-1:0] buf_data_q [BUF_DEPTH];
  logic [TAG_W-1:0]  buf_tag_q  [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              buf_empty, buf_full;
  logic              push, pop, buf_write, overrun_set;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign buf_empty = (cnt_q == '0);
  assign buf_full  = (cnt_q == BUF_FULL);

  // ---------------------------------------------------------------- arbitration
  logic [1:0]        out_resp_d;
  logic [DATA_W-1:0] out_data_d;
  logic [TAG_W-1:0]  out_tag_d;

  always_comb begin
    out_resp_d = RESP_NONE;
    out_data_d = '0;
    out_tag_d  = '0;
    pop        = 1'b0;
    push       = 1'b0;
    if (l2_v_q) begin
      out_resp_d = l2_resp_q;
      out_data_d = l2_data_q;
      out_tag_d  = l2_tag_q;
      push       = sh_v;
    end else if (!buf_empty) begin
      out_resp_d = buf_resp_q[rd_ptr_q];
      out_data_d = buf_data_q[rd_ptr_q];
      out_tag_d  = buf_tag_q[rd_ptr_q];
      pop        = 1'b1;
      push       = sh_v;
    end else if (sh_v) begin
      out_resp_d = sh_resp;
      out_data_d = sh_data;
      out_tag_d  = tag_q;
    end
  end

  // A simultaneous pop frees the slot, so only a push without a pop can overrun.
  assign overrun_set = push && buf_full && !pop;
  assign buf_write   = push && !overrun_set;
  assign cnt_d       = cnt_q + CNT_W'(buf_write) - CNT_W'(pop);

  always_ff @(posedge c_clk) begin
    if (buf_write) begin
      buf_resp_q[wr_ptr_q] <= sh_resp;
      buf_data_q[wr_ptr_q] <= sh_data;
      buf_tag_q[wr_ptr_q]  <= tag_q;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_resp    <= RESP_NONE;
      out_data    <= '0;
      out_tag     <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (buf_write) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)       rd_ptr_q <= next_ptr(rd_ptr_q);
      cnt_q       <= cnt_d;
      out_resp    <= out_resp_d;
      out_data    <= out_data_d;
      out_tag     <= out_tag_d;
      err_overrun <= err_overrun | overrun_set;
    end
  end

endmodule
